// File: rtl/waterlight_apb_ctrl.sv
// waterlight_apb_ctrl
// APB3 register slave that programs the LED water-light engine: mode select,
// speed (half-period) and a one-cycle PWM counter-clear pulse.
// Optional autoplay sequencer (modes 01 -> 02 -> 03 -> 01 at a programmable
// dwell interval) is compiled in when WATERLIGHT_AUTOPLAY_EN is defined;
// without it DWELL, CTRL.AUTO and STATUS[31:16] read 0 and ignore writes.
module waterlight_apb_ctrl (
  input  logic        clk,
  input  logic        RSTn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [11:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [7:0]  WaterLight_mode,
  output logic [31:0] WaterLight_speed,
  output logic        pwm_cnt_clear
);

  // Word offsets within the 32-byte register window.
  localparam logic [2:0]  OFF_MODE   = 3'd0;
  localparam logic [2:0]  OFF_SPEED  = 3'd1;
  localparam logic [2:0]  OFF_CTRL   = 3'd2;
  localparam logic [2:0]  OFF_STATUS = 3'd3;
  localparam logic [2:0]  OFF_DWELL  = 3'd4;

  localparam logic [7:0]  MODE_RST   = 8'h01;
  localparam logic [31:0] SPEED_RST  = 32'h00B7_1B00;
  localparam logic [31:0] SPEED_MIN  = 32'd16;

  logic [2:0]  off_s;
  logic        setup_s;
  logic        access_s;
  logic        err_s;
  logic        wr_s;
  logic        mode_wr_s;
  logic        speed_wr_s;
  logic        ctrl_wr_s;
  logic        ctrl_clr_s;
  logic [31:0] rd_val_s;
  logic        unused_addr_s;

  // Values supplied by the autoplay section (tied off when it is absent).
  logic        advance_s;
  logic        auto_s;
  logic [31:0] dwell_s;
  logic [15:0] adv_cnt_s;
  logic [7:0]  mode_next_s;

  logic [7:0]  mode_q,    mode_d;
  logic [31:0] speed_q,   speed_d;
  logic [31:0] prdata_q,  prdata_d;
  logic        pslverr_q, pslverr_d;
  logic        clr_q,     clr_d;

  assign off_s         = PADDR[4:2];
  assign setup_s       = PSEL & ~PENABLE;
  assign access_s      = PSEL & PENABLE;
  assign wr_s          = access_s & PWRITE & ~err_s;
  assign mode_wr_s     = wr_s & (off_s == OFF_MODE);
  assign speed_wr_s    = wr_s & (off_s == OFF_SPEED);
  assign ctrl_wr_s     = wr_s & (off_s == OFF_CTRL);
  assign ctrl_clr_s    = ctrl_wr_s & PWDATA[0];
  // Byte-lane bits of the address carry no meaning for word registers.
  assign unused_addr_s = ^PADDR[1:0];

`ifdef WATERLIGHT_AUTOPLAY_EN
  localparam logic [0:0]  ST_IDLE   = 1'b0;
  localparam logic [0:0]  ST_RUN    = 1'b1;
  localparam logic [31:0] DWELL_RST = 32'h016E_3600;

  logic [0:0]  state_q, state_d;
  logic        auto_q,  auto_d;
  logic [31:0] dwell_q, dwell_d;
  logic [31:0] cnt_q,   cnt_d;
  logic [15:0] adv_q,   adv_d;
  logic        dwell_wr_s;

  // Autoplay step: 01 -> 02 -> 03 -> 01; anything else restarts at 01.
  function automatic logic [7:0] next_mode(input logic [7:0] m);
    logic [7:0] n;
    case (m)
      8'h01:   n = 8'h02;
      8'h02:   n = 8'h03;
      default: n = 8'h01;
    endcase
    return n;
  endfunction

  assign dwell_wr_s  = wr_s & (off_s == OFF_DWELL);
  assign advance_s   = (state_q == ST_RUN) & (cnt_q == dwell_q);
  assign mode_next_s = next_mode(mode_q);
  assign auto_s      = auto_q;
  assign dwell_s     = dwell_q;
  assign adv_cnt_s   = adv_q;

  // Sequencer next state: AUTO/DWELL writes, dwell counting, advance count.
  always_comb begin
    state_d = state_q;
    auto_d  = auto_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    adv_d   = adv_q;
    if (ctrl_wr_s) begin
      auto_d = PWDATA[1];
    end else begin
      auto_d = auto_q;
    end
    if (dwell_wr_s) begin
      dwell_d = PWDATA;
    end else begin
      dwell_d = dwell_q;
    end
    case (state_q)
      ST_IDLE: begin
        // Counter held at zero so it starts fresh on entry to RUN.
        cnt_d = 32'd0;
        if (ctrl_wr_s && PWDATA[1]) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // A DWELL rewrite below the current count lets it wrap at 2^32.
        if (cnt_q == dwell_q) begin
          cnt_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
        if (ctrl_wr_s && !PWDATA[1]) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 32'd0;
      end
    endcase
    // A MODE write landing on an advance overrides it and is not counted.
    if (advance_s && !mode_wr_s) begin
      adv_d = adv_q + 16'd1;
    end else begin
      adv_d = adv_q;
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      auto_q  <= 1'b0;
      dwell_q <= DWELL_RST;
      cnt_q   <= 32'd0;
      adv_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      auto_q  <= auto_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      adv_q   <= adv_d;
    end
  end
`else
  assign advance_s   = 1'b0;
  assign auto_s      = 1'b0;
  assign dwell_s     = 32'd0;
  assign adv_cnt_s   = 16'd0;
  assign mode_next_s = mode_q;
`endif

  // Decode error: out-of-window address, reserved offset or STATUS write.
  always_comb begin
    err_s = 1'b0;
    if (PADDR[11:5] != 7'd0) begin
      err_s = 1'b1;
    end else begin
      case (off_s)
        OFF_MODE, OFF_SPEED, OFF_CTRL, OFF_DWELL: err_s = 1'b0;
        OFF_STATUS: err_s = PWRITE;
        default:    err_s = 1'b1;
      endcase
    end
  end

  // Read multiplexer; CLR always reads back 0.
  always_comb begin
    rd_val_s = 32'd0;
    case (off_s)
      OFF_MODE:   rd_val_s = {24'd0, mode_q};
      OFF_SPEED:  rd_val_s = speed_q;
      OFF_CTRL:   rd_val_s = {30'd0, auto_s, 1'b0};
      OFF_STATUS: rd_val_s = {adv_cnt_s, mode_q, 7'd0, auto_s};
      OFF_DWELL:  rd_val_s = dwell_s;
      default:    rd_val_s = 32'd0;
    endcase
  end

  // Capture read data and error flag in the setup cycle so both are stable
  // for the whole access phase.
  always_comb begin
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    if (setup_s && !PWRITE) begin
      prdata_d = err_s ? 32'd0 : rd_val_s;
    end else begin
      prdata_d = prdata_q;
    end
    if (setup_s) begin
      pslverr_d = err_s;
    end else if (access_s) begin
      pslverr_d = 1'b0;
    end else begin
      pslverr_d = pslverr_q;
    end
  end

  // Engine-facing registers and the merged clear pulse request.
  always_comb begin
    mode_d  = mode_q;
    speed_d = speed_q;
    if (mode_wr_s) begin
      mode_d = PWDATA[7:0];
    end else if (advance_s) begin
      mode_d = mode_next_s;
    end else begin
      mode_d = mode_q;
    end
    if (speed_wr_s) begin
      // Very short half-periods are clamped to keep the engine sane.
      if (PWDATA < SPEED_MIN) begin
        speed_d = SPEED_MIN;
      end else begin
        speed_d = PWDATA;
      end
    end else begin
      speed_d = speed_q;
    end
    // OR of all sources: coincident requests collapse into one pulse.
    clr_d = mode_wr_s | speed_wr_s | ctrl_clr_s | advance_s;
  end

  // Bus-side and engine-side registers.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      mode_q    <= MODE_RST;
      speed_q   <= SPEED_RST;
      prdata_q  <= 32'd0;
      pslverr_q <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      speed_q   <= speed_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      clr_q     <= clr_d;
    end
  end

  assign PRDATA           = prdata_q;
  assign PREADY           = 1'b1;
  assign PSLVERR          = pslverr_q;
  assign WaterLight_mode  = mode_q;
  assign WaterLight_speed = speed_q;
  assign pwm_cnt_clear    = clr_q;

endmodule

// File: tb/tb_waterlight_apb_ctrl.sv
// Testbench for waterlight_apb_ctrl: randomized APB traffic against a
// register-level reference model, scoreboard-checked access responses and
// clear pulses, plus directed autoplay and reset-during-transfer sequences.
`timescale 1ns/1ps
module tb_waterlight_apb_ctrl;

`ifdef WATERLIGHT_AUTOPLAY_EN
  localparam bit AP_EN = 1'b1;
`else
  localparam bit AP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RSTn = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [11:0] PADDR = 12'd0;
  logic [31:0] PWDATA = 32'd0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [7:0]  WaterLight_mode;
  logic [31:0] WaterLight_speed;
  logic        pwm_cnt_clear;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    bit          is_read;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t sb_q[$];
  int   pulse_q[$];

  // Reference model state
  logic [7:0]  m_mode;
  logic [31:0] m_speed;
  logic [31:0] m_dwell;
  bit          m_auto;
  logic [15:0] m_adv;

  waterlight_apb_ctrl dut (
    .clk(clk), .RSTn(RSTn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .WaterLight_mode(WaterLight_mode),
    .WaterLight_speed(WaterLight_speed), .pwm_cnt_clear(pwm_cnt_clear)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode  = 8'h01;
    m_speed = 32'h00B7_1B00;
    m_dwell = AP_EN ? 32'h016E_3600 : 32'd0;
    m_auto  = 1'b0;
    m_adv   = 16'd0;
  endtask

  task automatic push_pulse(input int c);
    if (pulse_q.size() == 0 || pulse_q[pulse_q.size()-1] != c) pulse_q.push_back(c);
  endtask

  function automatic bit exp_err(input logic [11:0] a, input bit wr);
    logic [2:0] o;
    o = a[4:2];
    return (a[11:5] != 7'd0) || (o >= 3'd5) || (wr && o == 3'd3);
  endfunction

  function automatic logic [31:0] exp_read(input logic [11:0] a);
    logic [31:0] v;
    if (exp_err(a, 1'b0)) return 32'd0;
    case (a[4:2])
      3'd0:    v = {24'd0, m_mode};
      3'd1:    v = m_speed;
      3'd2:    v = {30'd0, m_auto, 1'b0};
      3'd3:    v = {m_adv, m_mode, 7'd0, m_auto};
      3'd4:    v = m_dwell;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] mode_after(input logic [7:0] start, input int n);
    logic [7:0] m;
    m = start;
    for (int k = 0; k < n; k++) m = (m == 8'h01) ? 8'h02 : (m == 8'h02) ? 8'h03 : 8'h01;
    return m;
  endfunction

  // Effect of a committed (non-error) write; called in the access cycle.
  task automatic model_write(input logic [11:0] a, input logic [31:0] d);
    case (a[4:2])
      3'd0: begin m_mode = d[7:0]; push_pulse(cyc + 1); end
      3'd1: begin m_speed = (d < 32'd16) ? 32'd16 : d; push_pulse(cyc + 1); end
      3'd2: begin
        if (d[0]) push_pulse(cyc + 1);
        if (AP_EN) m_auto = d[1];
      end
      3'd4: if (AP_EN) m_dwell = d;
      default: ;
    endcase
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    bit e;
    e = exp_err(a, 1'b1);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    sb_q.push_back('{1'b0, 32'd0, e});
    @(posedge clk); #1;
    PENABLE = 1'b1;
    if (!e) model_write(a, d);
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read_x(input logic [11:0] a, input logic [31:0] expv, input bit e);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    sb_q.push_back('{1'b1, expv, e});
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a);
    apb_read_x(a, exp_read(a), exp_err(a, 1'b0));
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_mode"}, 32'(WaterLight_mode), 32'(m_mode));
    chk({tag, "_speed"}, WaterLight_speed, m_speed);
  endtask

  task automatic read_all();
    for (int i = 0; i < 5; i++) apb_read(12'(i * 4));
  endtask

  // Monitor: access-phase responses against the scoreboard, and the clear
  // pulse against the list of cycles where one is expected.
  always @(negedge clk) begin
    exp_t e;
    bit   pe;
    if (RSTn) begin
      if (PSEL && PENABLE && PREADY) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_access actual=access expected=none (cycle %0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          chk("pslverr", 32'(PSLVERR), 32'(e.err));
          if (e.is_read) chk("prdata", PRDATA, e.rdata);
        end
      end
      pe = (pulse_q.size() > 0) && (pulse_q[0] == cyc);
      chk("pwm_cnt_clear", 32'(pwm_cnt_clear), 32'(pe));
      if (pe) void'(pulse_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] a;
    logic [31:0] d;
    logic [6:0]  hi;
    logic [1:0]  lo;
    int          r;
`ifdef WATERLIGHT_AUTOPLAY_EN
    int          e0;
`endif

    model_reset();
    repeat (3) @(posedge clk);
    #1 RSTn = 1'b1;

    // Reset state
    check_outputs("rst");
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_pslverr", 32'(PSLVERR), 32'd0);
    read_all();

    // SPEED clamp and boundaries
    apb_write(12'h004, 32'd5);   check_outputs("spd5");
    apb_read(12'h004);
    apb_write(12'h004, 32'd15);  check_outputs("spd15");
    apb_write(12'h004, 32'd16);  check_outputs("spd16");
    apb_write(12'h004, 32'd17);  check_outputs("spd17");
    apb_read(12'h004);

    // CLR pulse, CTRL read-back
    apb_write(12'h008, 32'h1);
    apb_read(12'h008);

    // Error responses leave state untouched
    apb_read(12'h020);
    apb_write(12'h014, 32'hDEAD_BEEF);
    apb_write(12'h00C, 32'hFFFF_FFFF);
    apb_write(12'h800, 32'h0000_0003);
    check_outputs("err");
    read_all();

`ifndef WATERLIGHT_AUTOPLAY_EN
    // Without autoplay: DWELL/AUTO writes are accepted but ignored
    apb_write(12'h010, 32'd7);
    apb_write(12'h008, 32'h2);
    apb_read(12'h010);
    apb_read(12'h008);
    apb_read(12'h00C);
`endif

    // Randomized traffic; AUTO kept clear so the model stays register-only
    for (int i = 0; i < 200; i++) begin
      r  = $urandom_range(0, 9);
      lo = 2'($urandom_range(0, 3));
      if (r < 8) begin
        a = {7'd0, 3'(r), lo};
      end else begin
        hi = 7'($urandom_range(1, 127));
        a  = {hi, 3'($urandom_range(0, 7)), lo};
      end
      d = $urandom;
      if (a[4:2] == 3'd1 && $urandom_range(0, 1) == 1) d = 32'($urandom_range(0, 40));
      if (a[4:2] == 3'd2) d[1] = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        apb_write(a, d);
        check_outputs("rnd");
      end else begin
        apb_read(a);
      end
    end

`ifdef WATERLIGHT_AUTOPLAY_EN
    // Autoplay: DWELL=3 gives an advance every 4 cycles after enabling
    apb_write(12'h010, 32'd3);
    apb_write(12'h000, 32'h2);
    apb_write(12'h008, 32'h2);
    e0 = cyc;
    for (int k = 1; k <= 3; k++) push_pulse(e0 + 4 * k + 1);
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      chk("ap_seq", 32'(WaterLight_mode), 32'(mode_after(8'h02, (cyc - e0) / 4)));
    end
    m_mode = mode_after(8'h02, 3);
    m_adv  = 16'd3;

    // MODE write committed on the very edge an advance is due
    @(posedge clk); #1;
    while (((cyc + 3 - e0) % 4) != 0) begin
      @(posedge clk); #1;
    end
    apb_write(12'h000, 32'h5);
    check_outputs("ap_coinc");
    e0 = cyc;
    push_pulse(e0 + 5);
    apb_read_x(12'h00C, {16'd3, 8'h05, 7'd0, 1'b1}, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ap_after", 32'(WaterLight_mode), 32'(mode_after(8'h05, (cyc - e0) / 4)));
    end
    // One more advance (edge e0+8) lands before the stop write commits
    push_pulse(e0 + 9);
    apb_write(12'h008, 32'h0);
    m_mode = mode_after(8'h05, 2);
    m_adv  = 16'd5;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("ap_hold", 32'(WaterLight_mode), 32'(m_mode));
    end
    apb_read(12'h00C);
    apb_read(12'h000);
    apb_write(12'h010, 32'd1000);
`endif

    // Reset asserted during a write's access phase, autoplay running
    apb_write(12'h008, 32'h2);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h000; PWDATA = 32'h7;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    #2 RSTn = 1'b0;
    model_reset();
    pulse_q.delete();
    #1;
    check_outputs("rst_async");
    chk("rst_async_pslverr", 32'(PSLVERR), 32'd0);
    chk("rst_async_prdata", PRDATA, 32'd0);
    chk("rst_async_clr", 32'(pwm_cnt_clear), 32'd0);
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(posedge clk); #1;
    RSTn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_outputs("rst_rel");
    read_all();

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("pulses_drained", 32'(pulse_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
